// File: rtl/dram_arbiter.sv
// dram_arbiter: shares the single-port data RAM between the MEM data port (D) and fetch port (I),
// sequencing CE, read latency, capture and ack, with D priority bounded by an I starvation limit.
module dram_arbiter #(
  parameter int ADDR_W   = 27,
  parameter int RAM_LAT  = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic [31:0]       d_rdata,
  output logic              d_stall,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic              i_ack,
  output logic [31:0]       i_rdata,
  output logic              i_stall,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic              busy,
  output logic              gnt_id
);
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
  state_t      state;
  logic [2:0]  lat_cnt;
  logic [3:0]  wait_cnt;
  logic        any_req, pick_i, fin, grant;
  always_comb begin
    any_req = d_req | i_req;
    grant   = (state == IDLE) & any_req;
    pick_i  = i_req & (~d_req | (wait_cnt == 4'(MAX_WAIT)));
    // fin marks the edge that enters RESP: writes and 1-cycle reads leave ACCESS directly
    fin     = ((state == ACCESS) & (ram_we | (RAM_LAT == 1))) | ((state == WAIT) & (lat_cnt == 3'd1));
  end
  assign busy    = state != IDLE;
  assign d_stall = d_req & ~d_ack;
  assign i_stall = i_req & ~i_ack;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      wait_cnt  <= '0;
      ram_ce    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      gnt_id    <= 1'b0;
      d_ack     <= 1'b0;
      i_ack     <= 1'b0;
      d_rdata   <= '0;
      i_rdata   <= '0;
    end else begin
      state   <= state == IDLE ? (any_req ? ACCESS : IDLE) : state == RESP ? IDLE : fin ? RESP : WAIT;
      lat_cnt <= state == ACCESS ? 3'(RAM_LAT - 1) : state == WAIT ? lat_cnt - 3'd1 : lat_cnt;
      ram_ce  <= grant;
      d_ack   <= fin & ~gnt_id;
      i_ack   <= fin & gnt_id;
      if (fin & ~ram_we & ~gnt_id) d_rdata <= ram_rdata;
      if (fin & ~ram_we & gnt_id) i_rdata <= ram_rdata;
      if (grant) begin
        gnt_id    <= pick_i;
        ram_we    <= pick_i ? i_we : d_we;
        ram_addr  <= pick_i ? i_addr : d_addr;
        ram_wdata <= pick_i ? i_wdata : d_wdata;
        wait_cnt  <= pick_i ? '0 : wait_cnt + 4'(i_req & (wait_cnt != 4'(MAX_WAIT)));
      end
    end
  end
endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter: two arbiters (RAM_LAT=1 and RAM_LAT=3) checked every cycle against a
// transaction-timeline model, plus directed accesses with hand-computed latencies and data.
module tb_dram_arbiter;
  localparam int AW = 27;
  localparam int MW = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  logic d_req [2], d_we [2], i_req [2], i_we [2];
  logic d_ack [2], i_ack [2], d_stall [2], i_stall [2];
  logic ram_ce [2], ram_we [2], busy [2], gnt_id [2];
  logic [AW-1:0] d_addr [2], i_addr [2], ram_addr [2];
  logic [31:0] d_wdata [2], i_wdata [2], d_rdata [2], i_rdata [2], ram_wdata [2], ram_rdata [2];
  int cyc = 0;
  int total = 0;
  int bad = 0;
  logic rec = 1'b0;
  logic gq0 [$];
  logic gq1 [$];
  int ce_cyc [2];
  logic ce_pend [2];
  logic [AW-1:0] ce_adr [2];
  logic m_act [2], m_g [2], m_w [2];
  int m_s [2], m_wc [2];
  logic [AW-1:0] m_a [2];
  logic [31:0] m_wd [2], m_drd [2], m_ird [2];

  function automatic logic [31:0] rom(logic [AW-1:0] a);
    return a == 27'h10 ? 32'hDEADBEEF : {5'h15, a} ^ 32'h5A5A_0000;
  endfunction
  function automatic int lat(int k);
    return k == 0 ? 1 : 3;
  endfunction

  for (genvar j = 0; j < 2; j++) begin : g
    localparam int L = j == 0 ? 1 : 3;
    dram_arbiter #(.ADDR_W(AW), .RAM_LAT(L), .MAX_WAIT(MW)) dut (
      .clk(clk), .rst(rst),
      .d_req(d_req[j]), .d_we(d_we[j]), .d_addr(d_addr[j]), .d_wdata(d_wdata[j]),
      .d_ack(d_ack[j]), .d_rdata(d_rdata[j]), .d_stall(d_stall[j]),
      .i_req(i_req[j]), .i_we(i_we[j]), .i_addr(i_addr[j]), .i_wdata(i_wdata[j]),
      .i_ack(i_ack[j]), .i_rdata(i_rdata[j]), .i_stall(i_stall[j]),
      .ram_ce(ram_ce[j]), .ram_we(ram_we[j]), .ram_addr(ram_addr[j]), .ram_wdata(ram_wdata[j]),
      .ram_rdata(ram_rdata[j]), .busy(busy[j]), .gnt_id(gnt_id[j])
    );
    // RAM drives real data only in the cycle it is due; junk otherwise exposes capture-timing errors
    assign ram_rdata[j] = (ram_ce[j] && L == 1) ? rom(ram_addr[j]) :
                          (ce_pend[j] && cyc == ce_cyc[j] + L - 1) ? rom(ce_adr[j]) : 32'hBAD00000 ^ 32'(cyc);
  end

  task automatic chk(string nm, int k, logic [63:0] a, logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s k=%0d cyc=%0d got=%0h want=%0h", nm, k, cyc, a, e);
    end
  endtask

  always @(posedge clk) begin
    logic win;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_act[k] = 1'b0; m_g[k] = 1'b0; m_w[k] = 1'b0; m_a[k] = '0; m_wd[k] = '0;
        m_drd[k] = '0; m_ird[k] = '0; m_wc[k] = 0;
        ce_pend[k] <= 1'b0;
      end else begin
        if (ram_ce[k]) begin
          ce_pend[k] <= 1'b1;
          ce_cyc[k] <= cyc;
          ce_adr[k] <= ram_addr[k];
        end
        if (m_act[k] && !m_w[k] && cyc == m_s[k] + lat(k)) begin
          if (m_g[k]) m_ird[k] = rom(m_a[k]);
          else m_drd[k] = rom(m_a[k]);
        end
        if ((!m_act[k] || cyc >= m_s[k] + (m_w[k] ? 1 : lat(k)) + 2) && (d_req[k] || i_req[k])) begin
          win = i_req[k] && (!d_req[k] || m_wc[k] == MW);
          m_wc[k] = win ? 0 : (i_req[k] && m_wc[k] < MW) ? m_wc[k] + 1 : m_wc[k];
          m_act[k] = 1'b1;
          m_s[k] = cyc;
          m_g[k] = win;
          m_w[k] = win ? i_we[k] : d_we[k];
          m_a[k] = win ? i_addr[k] : d_addr[k];
          m_wd[k] = win ? i_wdata[k] : d_wdata[k];
        end
      end
    end
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    int n, s;
    logic on, dk, ik;
    for (int k = 0; k < 2; k++) begin
      n = m_w[k] ? 1 : lat(k);
      s = m_s[k];
      on = !rst && m_act[k];
      dk = on && !m_g[k] && cyc == s + 1 + n;
      ik = on && m_g[k] && cyc == s + 1 + n;
      chk("ram_ce", k, ram_ce[k], on && cyc == s + 1);
      chk("busy", k, busy[k], on && cyc >= s + 1 && cyc <= s + 1 + n);
      chk("d_ack", k, d_ack[k], dk);
      chk("i_ack", k, i_ack[k], ik);
      chk("d_stall", k, d_stall[k], d_req[k] && !dk);
      chk("i_stall", k, i_stall[k], i_req[k] && !ik);
      chk("ram_we", k, ram_we[k], rst ? 1'b0 : m_w[k]);
      chk("ram_addr", k, ram_addr[k], rst ? '0 : m_a[k]);
      chk("ram_wdata", k, ram_wdata[k], rst ? '0 : m_wd[k]);
      chk("gnt_id", k, gnt_id[k], rst ? 1'b0 : m_g[k]);
      chk("d_rdata", k, d_rdata[k], rst ? '0 : m_drd[k]);
      chk("i_rdata", k, i_rdata[k], rst ? '0 : m_ird[k]);
      if (rec && ram_ce[k]) begin
        if (k == 0) gq0.push_back(gnt_id[k]);
        else gq1.push_back(gnt_id[k]);
      end
    end
  end

  task automatic run(int k, logic port, logic we, logic [AW-1:0] a, logic [31:0] wd, output int got);
    int c0;
    c0 = cyc;
    got = -1;
    if (port) begin
      i_req[k] = 1'b1; i_we[k] = we; i_addr[k] = a; i_wdata[k] = wd;
    end else begin
      d_req[k] = 1'b1; d_we[k] = we; d_addr[k] = a; d_wdata[k] = wd;
    end
    for (int t = 0; t < 20 && got < 0; t++) begin
      @(negedge clk);
      if (port ? i_ack[k] : d_ack[k]) got = cyc - c0;
    end
    if (got < 0) begin
      total++;
      bad++;
      $display("FAIL ack_timeout k=%0d port=%0d got=none want=ack", k, port);
    end
    @(posedge clk);
    #1;
    if (port) i_req[k] = 1'b0;
    else d_req[k] = 1'b0;
  endtask

  initial begin
    int l;
    logic exp_g [10];
    exp_g = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    for (int k = 0; k < 2; k++) begin
      d_req[k] = 0; d_we[k] = 0; d_addr[k] = '0; d_wdata[k] = '0;
      i_req[k] = 0; i_we[k] = 0; i_addr[k] = '0; i_wdata[k] = '0;
    end
    #1 rst = 1'b1;
    @(posedge clk);
    #2;
    chk("rst_busy", 1, busy[1], 0);
    chk("rst_d_rdata", 0, d_rdata[0], 0);
    chk("rst_ram_ce", 0, ram_ce[0], 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    run(0, 0, 0, 27'h10, 32'h0, l);
    chk("t1_lat", 0, l, 2);
    chk("t1_rdata", 0, d_rdata[0], 32'hDEADBEEF);
    repeat (2) @(posedge clk);
    #1;
    chk("t1_hold", 0, d_rdata[0], 32'hDEADBEEF);
    run(0, 0, 1, 27'h20, 32'h12345678, l);
    chk("t2_lat", 0, l, 2);
    chk("t2_rdata", 0, d_rdata[0], 32'hDEADBEEF);
    chk("t2_addr", 0, ram_addr[0], 27'h20);
    chk("t2_wdata", 0, ram_wdata[0], 32'h12345678);
    chk("t2_we", 0, ram_we[0], 1);
    run(0, 1, 0, 27'h33, 32'h0, l);
    chk("ird_lat", 0, l, 2);
    chk("ird_data", 0, i_rdata[0], 32'hF25A0033);
    for (int k = 0; k < 2; k++) begin
      d_req[k] = 1; d_we[k] = 0; d_addr[k] = 27'h40;
      i_req[k] = 1; i_we[k] = 0; i_addr[k] = 27'h50;
    end
    rec = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    rec = 1'b0;
    for (int k = 0; k < 2; k++) begin
      d_req[k] = 0;
      i_req[k] = 0;
    end
    repeat (8) @(posedge clk);
    #1;
    chk("t3_cnt0", 0, gq0.size() >= 10, 1);
    chk("t3_cnt1", 1, gq1.size() >= 10, 1);
    for (int i = 0; i < 10 && gq0.size() >= 10 && gq1.size() >= 10; i++) begin
      chk("t3_gnt0", 0, gq0[i], exp_g[i]);
      chk("t3_gnt1", 1, gq1[i], exp_g[i]);
    end
    run(1, 1, 0, 27'h77, 32'h0, l);
    chk("t4_lat", 1, l, 4);
    chk("t4_rdata", 1, i_rdata[1], 32'hF25A0077);
    run(1, 0, 1, 27'h05, 32'hCAFEF00D, l);
    chk("t4_wlat", 1, l, 2);
    i_req[1] = 1; i_we[1] = 0; i_addr[1] = 27'h99;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("t5_busy", 1, busy[1], 0);
    chk("t5_iack", 1, i_ack[1], 0);
    chk("t5_irdata", 1, i_rdata[1], 0);
    chk("t5_gnt", 1, gnt_id[1], 0);
    chk("t5_drdata0", 0, d_rdata[0], 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    run(1, 1, 0, 27'h99, 32'h0, l);
    chk("t5_lat", 1, l, 4);
    chk("t5_rdata", 1, i_rdata[1], 32'hF25A0099);
    repeat (4) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
